brick_field: RTL and testbench
==============================

Name: brick_field

Overview:
- Owns the row of breakable bricks for breakout mode.
- Once per animation frame, scans every live brick against the ball bounding box and produces the packed 2-bit-per-brick collision vector that the ball mover consumes as hit_block.
- Retires each brick whose hit the mover has consumed, tracks the remaining-brick count and flags a cleared field.
- Sits directly upstream of the ball/square mover, alongside the display renderer, which reads o_alive.

Parameters:
- N_BLK, 17, number of bricks; the output vector width is 2*N_BLK (34 by default).
- X0, 6, left x of brick 0.
- BLK_W, 34, brick width in pixels.
- BLK_GAP, 3, horizontal gap between bricks; brick i spans x = X0+i*(BLK_W+BLK_GAP) to that value +BLK_W.
- ROW_Y, 40, top y of the brick row.
- BLK_H, 16, brick height; the bottom edge is ROW_Y+BLK_H.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ani_stb  in  1  frame strobe, one i_clk pulse per frame
- i_animate  in  1  animation enable
- i_mode  in  1  breakout mode active; low restores the field
- i_start  in  1  restart request
- i_endgame  in  1  game over, from the mover
- i_x1, i_x2, i_y1, i_y2  in  12 each  ball left/right/top/bottom edges
- o_hit_block  out  2*N_BLK  per-brick code; brick i occupies bits [2i+1:2i]
- o_alive  out  N_BLK  live-brick mask
- o_remaining  out  5  live-brick count
- o_cleared  out  1  high when o_remaining==0
- o_busy  out  1  high while a scan is in progress

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - o_alive all 1, o_remaining=N_BLK, o_hit_block=0, o_cleared=0, o_busy=0, state IDLE.
- Restore (synchronous, same values as reset), triggered by either:
  - i_mode==0, or
  - i_start & i_endgame.
  - Restore has priority over all other activity, and any scan in progress is aborted.
- Frame event is defined as i_ani_stb & i_animate & i_mode & !i_endgame. On each frame event:
  - For each brick with a nonzero code in o_hit_block: clear its o_alive bit and subtract the popcount of nonzero codes from o_remaining. This is the commit of the result the mover consumed at this same strobe.
  - Clear o_hit_block.
  - Set the scan index to 0 and enter SCAN.
- SCAN state:
  - One brick per cycle, index 0..N_BLK-1; o_busy=1.
  - A dead brick yields code 00.
  - A live brick is classified using ox = min(i_x2,bx2) - max(i_x1,bx1) and oy = min(i_y2,by2) - max(i_y1,by1), computed as 13-bit signed.
  - No hit (00) unless ox>0 and oy>0; edges that only touch do not count.
  - ox>oy gives 01 (vertical bounce).
  - oy>ox gives 10 (horizontal bounce).
  - ox==oy gives 11 (corner).
  - Codes accumulate in a shadow register.
- PUBLISH state:
  - Occupies the cycle after index N_BLK-1.
  - Copies the shadow register to o_hit_block, drops o_busy and returns to IDLE.
  - Latency from the frame strobe to a valid o_hit_block is N_BLK+1 cycles.
- o_hit_block is held stable through the next frame strobe cycle inclusive, then cleared on that edge.
- A frame event during SCAN:
  - Aborts the scan and restarts it at index 0.
  - Still performs the commit/clear of the currently published vector.
- i_endgame high:
  - o_hit_block is forced to 0 on the next edge.
  - No frame events fire; o_alive is frozen.
- o_cleared is a registered comparison, updated the cycle after o_remaining changes.
- Bricks are never revived except by reset or restore.
- o_remaining never underflows: a brick is only counted while its alive bit is 1.

Optional Feature:
- Macro: BRICK_SINGLE_HIT_EN.
- Defined:
  - Per scan, only the lowest-index hit brick gets a nonzero code; later hits in the same scan are forced to 00.
  - Consequence: at most one brick is retired per frame, and the mover never double-toggles a direction.
- Undefined: all hit bricks are reported and retired in the same frame.

Decomposition:
- Shared package brick_pkg holds:
  - Hit code constants HIT_NONE=2'b00, HIT_Y=2'b01, HIT_X=2'b10, HIT_XY=2'b11.
  - The FSM state encoding (IDLE, SCAN, PUBLISH).
  - A brick-geometry function returning bx1/bx2 for an index.
- One combinational sub-module, brick_hit_classify:
  - Inputs: ball box and brick box.
  - Output: the 2-bit code.
  - Instanced once and time-multiplexed by the scan index.

Test Plan:
- Reset release, no strobe -> o_alive=17'h1FFFF, o_remaining=17, o_hit_block=0, o_cleared=0.
- Ball box x 10..26, y 50..66 (ox=16, oy=6 vs brick 0 spanning x 6..40, y 40..56); strobe -> 18 cycles later o_hit_block=34'h1. Next strobe -> o_alive[0]=0, o_remaining=16, o_hit_block=0.
- Ball box x 30..46, y 42..58 -> brick 0 code 10 and brick 1 code 10, o_hit_block=34'hA; with BRICK_SINGLE_HIT_EN -> 34'h2, and only brick 0 is retired at the next strobe.
- Ball box x 34..50, y 50..66 vs brick 0 (ox=6, oy=6) -> code 11, o_hit_block[1:0]=2'b11. A box touching brick 0 exactly at x=40 -> code 00.
- Second strobe issued 5 cycles into a scan -> scan restarts, o_busy stays high, and the publish lands 18 cycles after the second strobe.
- Retire all 17 bricks -> o_cleared=1. Then i_endgame=1 with i_start=1 -> next cycle o_alive all 1, o_remaining=17, o_cleared=0. Also: i_rst_n asserted mid-scan -> immediate reset values.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared definitions for the breakout brick row: hit codes, scan FSM states
// and the horizontal geometry of each brick.
package brick_pkg;

  localparam logic [1:0] HIT_NONE = 2'b00;
  localparam logic [1:0] HIT_Y    = 2'b01;
  localparam logic [1:0] HIT_X    = 2'b10;
  localparam logic [1:0] HIT_XY   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PUBLISH
  } scan_state_e;

  typedef struct packed {
    logic [11:0] bx1;
    logic [11:0] bx2;
  } brick_span_t;

  // Left/right x of brick idx; bricks sit on a fixed pitch of width plus gap.
  function automatic brick_span_t brick_span(input int idx, input int x0,
                                             input int blk_w, input int blk_gap);
    brick_span_t s;
    s.bx1 = 12'(x0 + idx * (blk_w + blk_gap));
    s.bx2 = 12'(x0 + idx * (blk_w + blk_gap) + blk_w);
    return s;
  endfunction

endpackage

// File: rtl/brick_field_if.sv
// Frame/ball inputs and brick-state outputs of brick_field.
// master: the ball mover side that drives the inputs; slave: brick_field itself.
interface brick_field_if #(
  parameter int N_BLK = 17
);
  logic                 i_ani_stb;
  logic                 i_animate;
  logic                 i_mode;
  logic                 i_start;
  logic                 i_endgame;
  logic [11:0]          i_x1;
  logic [11:0]          i_x2;
  logic [11:0]          i_y1;
  logic [11:0]          i_y2;
  logic [2*N_BLK-1:0]   o_hit_block;
  logic [N_BLK-1:0]     o_alive;
  logic [4:0]           o_remaining;
  logic                 o_cleared;
  logic                 o_busy;

  modport master (
    output i_ani_stb, i_animate, i_mode, i_start, i_endgame,
    output i_x1, i_x2, i_y1, i_y2,
    input  o_hit_block, o_alive, o_remaining, o_cleared, o_busy
  );

  modport slave (
    input  i_ani_stb, i_animate, i_mode, i_start, i_endgame,
    input  i_x1, i_x2, i_y1, i_y2,
    output o_hit_block, o_alive, o_remaining, o_cleared, o_busy
  );
endinterface

// File: rtl/brick_hit_classify.sv
// Combinational overlap classifier: ball box vs one brick box -> 2-bit hit code.
// Touching edges give zero overlap and therefore no hit.
module brick_hit_classify
  import brick_pkg::*;
(
  input  logic [11:0] x1,
  input  logic [11:0] x2,
  input  logic [11:0] y1,
  input  logic [11:0] y2,
  input  logic [11:0] bx1,
  input  logic [11:0] bx2,
  input  logic [11:0] by1,
  input  logic [11:0] by2,
  output logic [1:0]  code
);
  logic [11:0]        lo_x, hi_x, lo_y, hi_y;
  logic signed [12:0] ox, oy;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the block can leave a value held, which would infer a latch.
  always_comb begin
    hi_x = (x2 < bx2) ? x2 : bx2;
    lo_x = (x1 > bx1) ? x1 : bx1;
    hi_y = (y2 < by2) ? y2 : by2;
    lo_y = (y1 > by1) ? y1 : by1;
    ox   = $signed({1'b0, hi_x}) - $signed({1'b0, lo_x});
    oy   = $signed({1'b0, hi_y}) - $signed({1'b0, lo_y});
    code = HIT_NONE;
    if (ox > 13'sd0 && oy > 13'sd0) begin
      if (ox > oy)      code = HIT_Y;
      else if (oy > ox) code = HIT_X;
      else              code = HIT_XY;
    end
  end
endmodule

// File: rtl/brick_field.sv
// Breakout brick row: per-frame serial collision scan, publish, retire and count.
// Optional BRICK_SINGLE_HIT_EN: only the lowest-index hit brick is reported per scan.
module brick_field
  import brick_pkg::*;
#(
  parameter int N_BLK   = 17,
  parameter int X0      = 6,
  parameter int BLK_W   = 34,
  parameter int BLK_GAP = 3,
  parameter int ROW_Y   = 40,
  parameter int BLK_H   = 16
) (
  input logic          i_clk,
  input logic          i_rst_n,
  brick_field_if.slave bus
);
  localparam int IW = $clog2(N_BLK + 1);

  scan_state_e        state_q, state_d;
  logic [IW-1:0]      idx_q;
  logic [2*N_BLK-1:0] shadow_q;
  logic [2*N_BLK-1:0] hit_q;
  logic [N_BLK-1:0]   alive_q;
  logic [4:0]         remaining_q;
  logic               cleared_q;

  logic               restore;
  logic               frame_evt;
  logic [N_BLK-1:0]   retire_mask;
  logic [4:0]         retire_cnt;
  brick_span_t        span;
  logic [1:0]         raw_code;
  logic [1:0]         scan_code;

  assign restore   = !bus.i_mode || (bus.i_start && bus.i_endgame);
  assign frame_evt = bus.i_ani_stb && bus.i_animate && bus.i_mode && !bus.i_endgame;

  assign span = brick_span(int'(idx_q), X0, BLK_W, BLK_GAP);

  brick_hit_classify u_classify (
    .x1   (bus.i_x1),
    .x2   (bus.i_x2),
    .y1   (bus.i_y1),
    .y2   (bus.i_y2),
    .bx1  (span.bx1),
    .bx2  (span.bx2),
    .by1  (12'(ROW_Y)),
    .by2  (12'(ROW_Y + BLK_H)),
    .code (raw_code)
  );

  always_comb begin
    scan_code = alive_q[idx_q] ? raw_code : HIT_NONE;
`ifdef BRICK_SINGLE_HIT_EN
    if (|shadow_q) scan_code = HIT_NONE;
`endif
  end

  // Only live bricks count, so the remaining count can never underflow.
  always_comb begin
    retire_mask = '0;
    for (int i = 0; i < N_BLK; i++)
      retire_mask[i] = alive_q[i] && (hit_q[2*i +: 2] != HIT_NONE);
  end
  assign retire_cnt = 5'($countones(retire_mask));

  always_comb begin
    state_d = state_q;
    if (restore || bus.i_endgame) begin
      state_d = IDLE;
    end else if (frame_evt) begin
      state_d = SCAN;
    end else begin
      case (state_q)
        SCAN:    if (idx_q == IW'(N_BLK - 1)) state_d = PUBLISH;
        PUBLISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q       <= '0;
      shadow_q    <= '0;
      hit_q       <= '0;
      alive_q     <= '1;
      remaining_q <= 5'(N_BLK);
      cleared_q   <= 1'b0;
    end else if (restore) begin
      idx_q       <= '0;
      shadow_q    <= '0;
      hit_q       <= '0;
      alive_q     <= '1;
      remaining_q <= 5'(N_BLK);
      cleared_q   <= 1'b0;
    end else begin
      cleared_q <= (remaining_q == 5'd0);
      if (bus.i_endgame) begin
        hit_q <= '0;
      end else if (frame_evt) begin
        // The mover consumed hit_q on this strobe: retire those bricks now.
        alive_q     <= alive_q & ~retire_mask;
        remaining_q <= remaining_q - retire_cnt;
        hit_q       <= '0;
        shadow_q    <= '0;
        idx_q       <= '0;
      end else begin
        case (state_q)
          SCAN: begin
            shadow_q[{idx_q, 1'b0} +: 2] <= scan_code;
            idx_q                        <= idx_q + 1'b1;
          end
          PUBLISH: hit_q <= shadow_q;
          default: ;
        endcase
      end
    end
  end

  assign bus.o_hit_block = hit_q;
  assign bus.o_alive     = alive_q;
  assign bus.o_remaining = remaining_q;
  assign bus.o_cleared   = cleared_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: an independent geometry model predicts each
// published hit vector and the brick retirements at the following strobe.
module tb_brick_field;
  localparam int N_BLK = 17;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  brick_field_if #(.N_BLK(N_BLK)) bus ();

  brick_field #(.N_BLK(N_BLK)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] sb_q[$];
  logic [16:0] m_alive;
  int          m_rem;
  logic [33:0] m_pub;
  int          cx1, cx2, cy1, cy2;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [33:0] model_hits(input int x1, input int x2, input int y1,
                                             input int y2, input logic [16:0] alive);
    logic [33:0] v;
    int l, r, ox, oy;
    logic [1:0] c;
`ifdef BRICK_SINGLE_HIT_EN
    bit found;
    found = 1'b0;
`endif
    v = '0;
    for (int i = 0; i < N_BLK; i++) begin
      l  = 6 + 37 * i;
      r  = l + 34;
      ox = ((x2 < r) ? x2 : r) - ((x1 > l) ? x1 : l);
      oy = ((y2 < 56) ? y2 : 56) - ((y1 > 40) ? y1 : 40);
      c  = 2'b00;
      if (alive[i] && ox > 0 && oy > 0)
        c = (ox > oy) ? 2'b01 : ((oy > ox) ? 2'b10 : 2'b11);
`ifdef BRICK_SINGLE_HIT_EN
      if (found) c = 2'b00;
      if (c != 2'b00) found = 1'b1;
`endif
      v[2*i +: 2] = c;
    end
    return v;
  endfunction

  function automatic logic [16:0] nz_mask(input logic [33:0] v);
    logic [16:0] m;
    for (int i = 0; i < N_BLK; i++) m[i] = |v[2*i +: 2];
    return m;
  endfunction

  task automatic model_reset();
    m_alive = '1;
    m_rem   = N_BLK;
    m_pub   = '0;
    sb_q.delete();
  endtask

  task automatic set_box(input int x1, input int x2, input int y1, input int y2);
    cx1 = x1; cx2 = x2; cy1 = y1; cy2 = y2;
    bus.i_x1 = 12'(x1); bus.i_x2 = 12'(x2);
    bus.i_y1 = 12'(y1); bus.i_y2 = 12'(y2);
  endtask

  task automatic check_restored(input string tag);
    check({tag, "_alive"},   bus.o_alive, 17'h1FFFF);
    check({tag, "_rem"},     bus.o_remaining, 17);
    check({tag, "_cleared"}, bus.o_cleared, 0);
    check({tag, "_hit"},     bus.o_hit_block, 0);
    check({tag, "_busy"},    bus.o_busy, 0);
  endtask

  // Frame strobe: commit what was published, then queue the new scan's result.
  task automatic strobe();
    logic [16:0] mk;
    if (sb_q.size() > 0) sb_q.delete(0);
    mk      = nz_mask(m_pub) & m_alive;
    m_alive = m_alive & ~mk;
    m_rem   = m_rem - $countones(mk);
    m_pub   = '0;
    sb_q.push_back(model_hits(cx1, cx2, cy1, cy2, m_alive));
    bus.i_ani_stb = 1'b1;
    @(posedge i_clk);
    #1 bus.i_ani_stb = 1'b0;
    check("commit_alive", bus.o_alive, m_alive);
    check("commit_rem",   bus.o_remaining, m_rem);
    check("strobe_hit_clear", bus.o_hit_block, 0);
    check("busy_start",   bus.o_busy, 1);
  endtask

  task automatic wait_publish();
    int lat;
    bit done;
    logic [33:0] exp;
    lat  = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge i_clk);
      #1 lat++;
      if (lat == 1) check("cleared_reg", bus.o_cleared, (m_rem == 0));
      if (!bus.o_busy) done = 1'b1;
    end
    check("publish_seen", done, 1);
    if (done) begin
      check("latency", lat, 18);
      check("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check("hit_block", bus.o_hit_block, exp);
        m_pub = exp;
      end
    end
  endtask

  task automatic restore_mode();
    bus.i_mode = 1'b0;
    @(posedge i_clk);
    #1 bus.i_mode = 1'b1;
    model_reset();
    check_restored("mode_restore");
  endtask

  initial begin
    bus.i_ani_stb = 1'b0;
    bus.i_animate = 1'b1;
    bus.i_mode    = 1'b1;
    bus.i_start   = 1'b0;
    bus.i_endgame = 1'b0;
    set_box(10, 26, 50, 66);
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1 check_restored("reset");

    // Single overlapping brick, then retire it.
    strobe();
    wait_publish();
    check("boxA_code", bus.o_hit_block, 34'h1);
    set_box(40, 42, 50, 66);
    strobe();
    check("boxA_retired", bus.o_alive[0], 0);
    wait_publish();

    // Ball straddling the gap between bricks 0 and 1.
    restore_mode();
    set_box(30, 46, 42, 58);
    strobe();
    wait_publish();
    set_box(40, 42, 50, 66);
    strobe();
    wait_publish();

    // Touching edge gives no hit; equal overlap is a corner.
    restore_mode();
    strobe();
    wait_publish();
    check("touch_code", bus.o_hit_block[1:0], 2'b00);
    set_box(34, 50, 50, 66);
    strobe();
    wait_publish();
    check("corner_code", bus.o_hit_block[1:0], 2'b11);

    // Second strobe 5 cycles into a scan restarts it.
    restore_mode();
    set_box(10, 26, 50, 66);
    strobe();
    repeat (5) begin
      @(posedge i_clk);
      #1 check("busy_mid_scan", bus.o_busy, 1);
    end
    strobe();
    wait_publish();

    // Endgame clears the published vector and blocks frame events.
    bus.i_endgame = 1'b1;
    @(posedge i_clk);
    #1 check("endgame_hit", bus.o_hit_block, 0);
    m_pub = '0;
    bus.i_ani_stb = 1'b1;
    @(posedge i_clk);
    #1 bus.i_ani_stb = 1'b0;
    check("endgame_alive", bus.o_alive, m_alive);
    check("endgame_busy",  bus.o_busy, 0);
    bus.i_endgame = 1'b0;

    // Retire every brick.
    restore_mode();
    set_box(0, 700, 42, 58);
    for (int k = 0; k < 20 && m_rem > 0; k++) begin
      strobe();
      wait_publish();
    end
    check("all_rem",     bus.o_remaining, 0);
    check("all_alive",   bus.o_alive, 0);
    check("all_cleared", bus.o_cleared, 1);

    // Restart after game over restores the field.
    bus.i_endgame = 1'b1;
    bus.i_start   = 1'b1;
    @(posedge i_clk);
    #1 bus.i_endgame = 1'b0;
    bus.i_start = 1'b0;
    model_reset();
    check_restored("start_restore");

    // Asynchronous reset in the middle of a scan.
    set_box(10, 26, 50, 66);
    strobe();
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 model_reset();
    check_restored("async_reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1 check_restored("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
